// File: rtl/uart_avm_responder_if.sv
// Avalon-MM slave bus bundle for the UART register-map responder.
// The master drives address/strobes/data; the slave returns readdata and waitrequest.
interface uart_avm_responder_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/uart_avm_responder.sv
// Avalon-MM RX/TX/STATUS register map backed by a TX FIFO (drained on a byte stream)
// and an RX FIFO (filled from a byte stream), used as the far-end responder of the image link.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waitrequest high; a pending read/write is captured on the next edge
// ST_ACK  | waitrequest low for one cycle; readdata shows the captured byte
module uart_avm_responder #(
    parameter int DEPTH = 16,
    parameter int LOG2D = 4
) (
    input  logic                  avm_clk,
    input  logic                  avm_rst,
    uart_avm_responder_if.slave   avm,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [LOG2D:0]        o_tx_level,
    output logic [LOG2D:0]        o_rx_level
);

    localparam logic [LOG2D:0] LVL_FULL  = (LOG2D+1)'(DEPTH);
    localparam logic [LOG2D:0] LVL_EMPTY = '0;
    localparam logic [4:0]     ADDR_RX   = 5'd0;
    localparam logic [4:0]     ADDR_TX   = 5'd4;
    localparam logic [4:0]     ADDR_STAT = 5'd8;

    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    state_t state_r, state_nx;
    logic   accept;
    logic   rd_acc, wr_acc;

    logic [7:0]       rdata_r, rdata_nx;
    logic             tx_ovf_r, rx_unf_r;
    logic [7:0]       status_byte;

    logic [7:0]       tx_mem [DEPTH];
    logic [LOG2D-1:0] tx_wptr, tx_rptr;
    logic [LOG2D:0]   tx_level;
    logic             tx_push, tx_pop, tx_full, tx_empty;

    logic [7:0]       rx_mem [DEPTH];
    logic [LOG2D-1:0] rx_wptr, rx_rptr;
    logic [LOG2D:0]   rx_level;
    logic             rx_push, rx_pop, rx_full, rx_empty;

    logic             unused_wdata;

    assign unused_wdata = ^avm.avm_writedata[31:8];

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) state_r <= ST_IDLE;
        else         state_r <= state_nx;
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: if (avm.avm_read || avm.avm_write) state_nx = ST_ACK;
            ST_ACK:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        accept              = 1'b0;
        avm.avm_waitrequest = 1'b1;
        avm.avm_readdata    = 32'd0;
        case (state_r)
            ST_IDLE: accept = avm.avm_read || avm.avm_write;
            ST_ACK: begin
                avm.avm_waitrequest = 1'b0;
                avm.avm_readdata    = {24'd0, rdata_r};
            end
            default: ;
        endcase
    end

    // A simultaneous read and write is treated as a read only.
    assign rd_acc = accept && avm.avm_read;
    assign wr_acc = accept && avm.avm_write && !avm.avm_read;

    assign tx_full  = (tx_level == LVL_FULL);
    assign tx_empty = (tx_level == LVL_EMPTY);
    assign rx_full  = (rx_level == LVL_FULL);
    assign rx_empty = (rx_level == LVL_EMPTY);

    assign tx_push = wr_acc && (avm.avm_address == ADDR_TX) && !tx_full;
    assign tx_pop  = !tx_empty && i_tx_ready;
    assign rx_push = i_rx_valid && !rx_full;
    assign rx_pop  = rd_acc && (avm.avm_address == ADDR_RX) && !rx_empty;

    assign status_byte = {!rx_empty, !tx_full, tx_ovf_r, rx_unf_r, 4'b0000};

    always_comb begin
        rdata_nx = 8'd0;
        if (rd_acc) begin
            case (avm.avm_address)
                ADDR_RX:   if (!rx_empty) rdata_nx = rx_mem[rx_rptr];
                ADDR_STAT: rdata_nx = status_byte;
                default:   rdata_nx = 8'd0;
            endcase
        end
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rdata_r  <= 8'd0;
            tx_ovf_r <= 1'b0;
            rx_unf_r <= 1'b0;
        end else begin
            if (accept) rdata_r <= rdata_nx;
            if (wr_acc && (avm.avm_address == ADDR_TX) && tx_full) tx_ovf_r <= 1'b1;
            if (rd_acc && (avm.avm_address == ADDR_RX) && rx_empty) rx_unf_r <= 1'b1;
            if (wr_acc && (avm.avm_address == ADDR_STAT)) begin
                if (avm.avm_writedata[5]) tx_ovf_r <= 1'b0;
                if (avm.avm_writedata[4]) rx_unf_r <= 1'b0;
            end
        end
    end

    // FIFO storage carries no reset; validity is tracked by pointers and levels.
    always_ff @(posedge avm_clk) begin
        if (tx_push) tx_mem[tx_wptr] <= avm.avm_writedata[7:0];
        if (rx_push) rx_mem[rx_wptr] <= i_rx_data;
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + 1'b1;
                2'b01:   tx_level <= tx_level - 1'b1;
                default: tx_level <= tx_level;
            endcase
        end
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_level <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + 1'b1;
                2'b01:   rx_level <= rx_level - 1'b1;
                default: rx_level <= rx_level;
            endcase
        end
    end

    assign o_tx_data  = tx_mem[tx_rptr];
    assign o_tx_valid = !tx_empty;
    assign o_rx_ready = !rx_full;
    assign o_tx_level = tx_level;
    assign o_rx_level = rx_level;

endmodule
